// File: rtl/video_xbar_sync.sv
// rtl/video_xbar_sync.sv - video crossbar with alias select, frame-aligned switching and switch timeout
module video_xbar_sync #(
  parameter int NUM_SRC        = 6,
  parameter int NUM_SINK       = 5,
  parameter int SEL_W          = 3,
  parameter int H_W            = 11,
  parameter int V_W            = 10,
  parameter int PIXEL_W        = 24,
  parameter int ALIAS_CODE     = 1,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SINK*SEL_W-1:0]   sink_sel,
  input  logic [SEL_W-1:0]            alias_sel,
  input  logic [NUM_SRC*H_W-1:0]      src_h_count,
  input  logic [NUM_SRC*V_W-1:0]      src_v_count,
  input  logic [NUM_SRC-1:0]          src_active_draw,
  input  logic [NUM_SRC*PIXEL_W-1:0]  src_pixel,
  output logic [NUM_SINK*H_W-1:0]     sink_h_count,
  output logic [NUM_SINK*V_W-1:0]     sink_v_count,
  output logic [NUM_SINK-1:0]         sink_active_draw,
  output logic [NUM_SINK*PIXEL_W-1:0] sink_pixel,
  output logic [NUM_SINK-1:0]         sink_pending,
  output logic [NUM_SINK-1:0]         sink_switched,
  output logic [NUM_SINK-1:0]         sink_timeout,
  output logic [NUM_SINK-1:0]         sink_invalid
);

  // Counter only has to reach TIMEOUT_CYCLES-1 before the forced commit.
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SEL_W-1:0] ALIAS    = SEL_W'(ALIAS_CODE);

  typedef enum logic {
    ST_LOCKED  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  // A code is unusable when it is the alias code itself or names no source.
  function automatic logic code_invalid(input logic [SEL_W-1:0] code);
    return (code == ALIAS) || (32'(code) >= 32'(NUM_SRC));
  endfunction

  logic [SEL_W-1:0]   res_q   [NUM_SINK];
  logic [SEL_W-1:0]   res_d   [NUM_SINK];
  state_e             state_q [NUM_SINK];
  state_e             state_d [NUM_SINK];
  logic [SEL_W-1:0]   com_q   [NUM_SINK];
  logic [SEL_W-1:0]   com_d   [NUM_SINK];
  logic [CNT_W-1:0]   cnt_q   [NUM_SINK];
  logic [CNT_W-1:0]   cnt_d   [NUM_SINK];

  logic [NUM_SRC-1:0]  src_fs;
  logic [NUM_SINK-1:0] tgt_fs;
  logic [NUM_SINK-1:0] commit_d;
  logic [NUM_SINK-1:0] forced_d;

  logic [H_W-1:0]      mux_h   [NUM_SINK];
  logic [V_W-1:0]      mux_v   [NUM_SINK];
  logic [PIXEL_W-1:0]  mux_pix [NUM_SINK];
  logic [NUM_SINK-1:0] mux_ad;
  logic [NUM_SINK-1:0] mux_inv;

  // Resolve each sink request, substituting alias_sel for the alias code
  always_comb begin
    for (int k = 0; k < NUM_SINK; k++) begin
      res_d[k] = sink_sel[k*SEL_W +: SEL_W];
      if (sink_sel[k*SEL_W +: SEL_W] == ALIAS) begin
        res_d[k] = alias_sel;
      end
    end
  end

  // Frame start per source; an invalid target is treated as always at frame start
  always_comb begin
    src_fs = '0;
    tgt_fs = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      src_fs[s] = (src_h_count[s*H_W +: H_W] == '0) && (src_v_count[s*V_W +: V_W] == '0);
    end
    for (int k = 0; k < NUM_SINK; k++) begin
      tgt_fs[k] = code_invalid(res_q[k]);
      for (int s = 0; s < NUM_SRC; s++) begin
        if ((res_q[k] == SEL_W'(s)) && src_fs[s]) begin
          tgt_fs[k] = 1'b1;
        end
      end
    end
  end

  // State register: resolved select, FSM state, committed source, wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_SINK; k++) begin
        res_q[k]   <= '0;
        state_q[k] <= ST_LOCKED;
        com_q[k]   <= '0;
        cnt_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_SINK; k++) begin
        res_q[k]   <= res_d[k];
        state_q[k] <= state_d[k];
        com_q[k]   <= com_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  // Next state: open a request, cancel it, or commit on frame start / timeout
  always_comb begin
    commit_d = '0;
    forced_d = '0;
    for (int k = 0; k < NUM_SINK; k++) begin
      state_d[k] = state_q[k];
      com_d[k]   = com_q[k];
      cnt_d[k]   = cnt_q[k];
      case (state_q[k])
        ST_LOCKED: begin
          if (res_q[k] != com_q[k]) begin
            state_d[k] = ST_PENDING;
            cnt_d[k]   = '0;
          end
        end
        ST_PENDING: begin
          // The target follows the resolved select, so a retarget keeps the count.
          if (res_q[k] == com_q[k]) begin
            state_d[k] = ST_LOCKED;
          end else if (tgt_fs[k]) begin
            state_d[k]  = ST_LOCKED;
            com_d[k]    = res_q[k];
            commit_d[k] = 1'b1;
          end else if (cnt_q[k] == CNT_LAST) begin
            state_d[k]  = ST_LOCKED;
            com_d[k]    = res_q[k];
            commit_d[k] = 1'b1;
            forced_d[k] = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
          end
        end
        default: state_d[k] = ST_LOCKED;
      endcase
    end
  end

  // Status decoded from FSM state
  always_comb begin
    sink_pending = '0;
    for (int k = 0; k < NUM_SINK; k++) begin
      sink_pending[k] = (state_q[k] == ST_PENDING);
    end
  end

  // Select the data of the next committed source so a commit loads the new stream
  always_comb begin
    for (int k = 0; k < NUM_SINK; k++) begin
      mux_h[k]   = '0;
      mux_v[k]   = '0;
      mux_pix[k] = '0;
      mux_ad[k]  = 1'b0;
      mux_inv[k] = code_invalid(com_d[k]);
      for (int s = 0; s < NUM_SRC; s++) begin
        if ((s != ALIAS_CODE) && (com_d[k] == SEL_W'(s))) begin
          mux_h[k]   = src_h_count[s*H_W +: H_W];
          mux_v[k]   = src_v_count[s*V_W +: V_W];
          mux_pix[k] = src_pixel[s*PIXEL_W +: PIXEL_W];
          mux_ad[k]  = src_active_draw[s];
        end
      end
    end
  end

  // Output registers: one cycle of latency on data and on the commit pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sink_h_count     <= '0;
      sink_v_count     <= '0;
      sink_active_draw <= '0;
      sink_pixel       <= '0;
      sink_switched    <= '0;
      sink_timeout     <= '0;
      sink_invalid     <= '0;
    end else begin
      for (int k = 0; k < NUM_SINK; k++) begin
        sink_h_count[k*H_W +: H_W]         <= mux_h[k];
        sink_v_count[k*V_W +: V_W]         <= mux_v[k];
        sink_active_draw[k]                <= mux_ad[k];
        sink_pixel[k*PIXEL_W +: PIXEL_W]   <= mux_pix[k];
        sink_invalid[k]                    <= mux_inv[k];
      end
      sink_switched <= commit_d;
      sink_timeout  <= forced_d;
    end
  end

endmodule

// File: doc/video_xbar_sync.md
Name: video_xbar_sync

Overview:
- Parametrised video crossbar that routes NUM_SRC video streams (h_count, v_count, active_draw, pixel) to NUM_SINK effect inputs and the final output.
- Successor to the fixed 5-sink effect-chain mux, with three additions: a generic alias code, frame-aligned (tear-free) source switching, and a switch timeout.
- Sits between the base pattern generator, the video effect blocks and the HDMI output stage.

Parameters:
- NUM_SRC, 6, number of source streams; index 0 is the base generator.
- NUM_SINK, 5, number of sink ports.
- SEL_W, 3, select code width; must satisfy 2**SEL_W > NUM_SRC.
- H_W, 11, h_count width.
- V_W, 10, v_count width.
- PIXEL_W, 24, pixel width.
- ALIAS_CODE, 1, select code meaning "use alias_sel".
- TIMEOUT_CYCLES, 2000000, maximum cycles a sink waits for a frame start before forcing the switch.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-low reset.
- sink_sel  in  NUM_SINK*SEL_W  requested source per sink; sink k uses bits [k*SEL_W +: SEL_W].
- alias_sel  in  SEL_W  source substituted wherever a select equals ALIAS_CODE.
- src_h_count  in  NUM_SRC*H_W  per-source h_count.
- src_v_count  in  NUM_SRC*V_W  per-source v_count.
- src_active_draw  in  NUM_SRC  per-source active_draw.
- src_pixel  in  NUM_SRC*PIXEL_W  per-source pixel.
- sink_h_count  out  NUM_SINK*H_W  routed h_count.
- sink_v_count  out  NUM_SINK*V_W  routed v_count.
- sink_active_draw  out  NUM_SINK  routed active_draw.
- sink_pixel  out  NUM_SINK*PIXEL_W  routed pixel.
- sink_pending  out  NUM_SINK  high while a switch is waiting for a frame start.
- sink_switched  out  NUM_SINK  one-cycle pulse when a switch commits.
- sink_timeout  out  NUM_SINK  one-cycle pulse when a switch is forced by timeout.
- sink_invalid  out  NUM_SINK  high while the committed source is invalid.

Behaviour:
- Reset (rst low, asynchronous):
  - all sink outputs 0; sink_pending, sink_switched, sink_timeout, sink_invalid all 0.
  - every sink's committed source = 0; resolved selects = 0; FSM = LOCKED; timeout counters = 0.
  - reset assertion mid-switch abandons the pending switch.
- Select resolution (registered, 1 cycle):
  - resolved = alias_sel if sink_sel == ALIAS_CODE, else sink_sel.
  - resolved is invalid if it equals ALIAS_CODE (alias points at itself) or is >= NUM_SRC.
  - Source code numbering is identical to select code numbering; code ALIAS_CODE is never a source.
- Datapath: each sink output is registered from its committed source, giving 1-cycle latency. If the committed source is invalid, the sink drives all-zero outputs and sink_invalid = 1.
- Frame start of source s: src_h_count[s] == 0 and src_v_count[s] == 0 in the current cycle. An invalid target counts as a frame start every cycle.
- Per-sink FSM:
  - LOCKED: if resolved != committed, go to PENDING with target = resolved and counter = 0.
  - PENDING:
    - sink_pending = 1; output continues from the old committed source.
    - If resolved changes, target is updated and the counter is not cleared.
    - If resolved == committed, return to LOCKED with no pulse (request cancelled).
    - If the target's frame start is seen, then in that same cycle: committed = target, the output register loads the target's data, sink_switched pulses, go to LOCKED.
    - Else if counter == TIMEOUT_CYCLES-1: commit as above and pulse sink_switched and sink_timeout together.
    - Otherwise the counter increments.
- Sink ports are independent; any number may commit in the same cycle. Several sinks may select the same source.
- Every bit of every output is defined in all states; there are no X assignments.

Test Plan:
- Reset, then present 6 sources with distinct pixels 0x000000+s*0x111111 → all sinks output source 0 pixel with 1-cycle latency; all status bits 0.
- Sink 2 select 0→3 mid-frame (src3 at h=100, v=50) → sink_pending=1 and the old source continues. When src3 reaches h=0,v=0, sink_switched[2] pulses once and the next output is src3's frame-start pixel.
- sink_sel[0]=ALIAS_CODE with alias_sel=4 → sink 0 follows src4 after its frame start. alias_sel=ALIAS_CODE → sink 0 outputs zeros with sink_invalid[0]=1, committed immediately.
- Target source counters held nonzero, TIMEOUT_CYCLES=16 → commit occurs exactly 16 cycles after PENDING entry; sink_switched and sink_timeout pulse together.
- Request 0→3, then back to 0 before src3's frame start → return to LOCKED with no pulse and output uninterrupted. Request 0→3→5 → commit on src5's frame start only.
- rst low asynchronously during PENDING → outputs 0 immediately; after release, sinks are locked to source 0 and not pending.
